// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared definitions for the multicycle RV32I controller:
//               state encoding, opcodes, ALUOp codes, datapath select
//               encodings, the per-state control bundle and its decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath select encodings
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore output decode: everything not listed for a state stays 0.
    function automatic ctrl_t state_outputs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.adr_src    = ADR_PC;
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = ADR_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = ADR_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;   // lw, I-type and everything else
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ALU_Decoder
// Description : Maps ALUOp/funct3/funct7 to the 3-bit ALU control code
//               (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt).
// Ports       : opb5_i     - opcode bit 5 (distinguishes R-type from I-type)
//               funct3_i   - instruction funct3
//               funct7b5_i - funct7 bit 5
//               alu_op_i   - ALUOp from the main FSM
//               alu_control_o - ALU operation select
// Revision    : 1.0 - initial release
// ============================================================================
module ALU_Decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       opb5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = 3'b000;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = 3'b000;
            ALUOP_SUB: alu_control_o = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type sub sets funct7[5]; for addi that bit is immediate.
                    3'b000:  alu_control_o = (opb5_i & funct7b5_i) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_o = 3'b101;
                    3'b100:  alu_control_o = 3'b100;
                    3'b110:  alu_control_o = 3'b011;
                    3'b111:  alu_control_o = 3'b010;
                    default: alu_control_o = 3'b000;
                endcase
            end
            default: alu_control_o = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_fsm
// Description : State register, next-state logic and registered Moore
//               output decode of the multicycle controller.
//               Optional macro MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE wait for
//               mem_ready_i, with ir_write/pc_update/mem_write gated by it.
// Ports       : clk, reset (async, active-high)
//               op_i        - opcode from IR
//               mem_ready_i - memory handshake (MEM_WAIT_EN only)
//               state_o     - current state
//               ctrl_o      - control bundle for the current state
// Revision    : 1.0 - initial release
// ============================================================================
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic       mem_ready_i,
    output state_t     state_o,
    output ctrl_t      ctrl_o
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_go;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_go           = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_go) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free
    // and line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_outputs(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_outputs(state_d);
        end
    end

    // Reset kills every write enable in the cycle it is asserted; the
    // memory handshake gates the side-effecting enables while waiting.
    always_comb begin
        ctrl_o = ctrl_q;
        if (reset) begin
            ctrl_o.ir_write  = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.reg_write = 1'b0;
            ctrl_o.pc_update = 1'b0;
            ctrl_o.branch    = 1'b0;
        end else if (!mem_go) begin
            ctrl_o.ir_write  = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.pc_update = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control unit of the multicycle RV32I core. Wraps the
//               main FSM, the PC write logic, the immediate-format decode
//               and the ALU decoder. Optional macro: MEM_WAIT_EN.
// Ports       : clk, reset (async, active-high); op/funct3/funct7 from IR;
//               zero (ALU flag); mem_ready; datapath selects and enables;
//               alu_control; illegal_instr (sticky); dbg_state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic [2:0]         alu_control,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] dbg_state
);

    state_t fsm_state;
    ctrl_t  ctrl;
    logic   unused_funct7;

    main_fsm u_main_fsm (
        .clk         (clk),
        .reset       (reset),
        .op_i        (op),
        .mem_ready_i (mem_ready),
        .state_o     (fsm_state),
        .ctrl_o      (ctrl)
    );

    ALU_Decoder u_alu_decoder (
        .opb5_i        (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7[5]),
        .alu_op_i      (ctrl.alu_op),
        .alu_control_o (alu_control)
    );

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign pc_write      = ctrl.pc_update | (ctrl.branch & zero);
    assign adr_src       = ctrl.adr_src;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign result_src    = ctrl.result_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign reg_write     = ctrl.reg_write;
    assign illegal_instr = ctrl.illegal;
    assign imm_src       = imm_src_of(op);
    assign dbg_state     = STATE_W'(fsm_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Table-driven self-checking bench for multicycle_controller,
//               plus hand-written sequences for trap hold, mid-cycle reset
//               and (with MEM_WAIT_EN) memory wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, mem_ready;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] dbg_state;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .dbg_state     (dbg_state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, a, b, imm;
        logic       rw;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        exp_t       ex;
    } vec_t;

    vec_t vecs[$];
    exp_t act;
    int   n_vec  = 0;
    int   n_miss = 0;

    assign act = {dbg_state, pc_write, adr_src, mem_write, ir_write, result_src,
                  alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal_instr};

    function automatic exp_t E(input logic [3:0] st, input logic pcw, input logic adr,
                               input logic mw, input logic irw, input logic [1:0] rs,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] imm, input logic rw,
                               input logic [2:0] alu, input logic ill);
        return {st, pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
    endfunction

    function automatic exp_t fetch_exp(input logic [1:0] imm);
        return E(S_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0);
    endfunction

    function automatic exp_t reset_exp(input logic [1:0] imm);
        return E(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0);
    endfunction

    function automatic exp_t decode_exp(input logic [1:0] imm);
        return E(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 3'b000, 0);
    endfunction

    function automatic exp_t aluwb_exp(input logic [1:0] imm);
        return E(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, 3'b000, 0);
    endfunction

    task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input exp_t e);
        vec_t v;
        v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.ex = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: state=%0d got %b, required state=%0d %b",
                     name, act.st, act, e.st, e);
        end
    endtask

    initial begin
        reset = 1'b1; op = T_LW; funct3 = 3'b000; funct7 = 7'h00;
        zero = 1'b0; mem_ready = 1'b1;

        // reset
        add(1, T_LW, 0, 0, 0, reset_exp(2'b00));
        // lw: 5 cycles
        add(0, T_LW, 0, 0, 0, fetch_exp(2'b00));
        add(0, T_LW, 0, 0, 0, decode_exp(2'b00));
        add(0, T_LW, 0, 0, 0, E(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0));
        add(0, T_LW, 0, 0, 0, E(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
        add(0, T_LW, 0, 0, 0, E(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
        // sw: 4 cycles
        add(0, T_SW, 0, 0, 0, fetch_exp(2'b01));
        add(0, T_SW, 0, 0, 0, decode_exp(2'b01));
        add(0, T_SW, 0, 0, 0, E(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0));
        add(0, T_SW, 0, 0, 0, E(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0));
        // R-type sub: 4 cycles
        add(0, T_R, 3'b000, 7'h20, 0, fetch_exp(2'b00));
        add(0, T_R, 3'b000, 7'h20, 0, decode_exp(2'b00));
        add(0, T_R, 3'b000, 7'h20, 0, E(S_EXECUTER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001, 0));
        add(0, T_R, 3'b000, 7'h20, 0, aluwb_exp(2'b00));
        // I-type ori: 4 cycles
        add(0, T_I, 3'b110, 7'h00, 0, fetch_exp(2'b00));
        add(0, T_I, 3'b110, 7'h00, 0, decode_exp(2'b00));
        add(0, T_I, 3'b110, 7'h00, 0, E(S_EXECUTEI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b011, 0));
        add(0, T_I, 3'b110, 7'h00, 0, aluwb_exp(2'b00));
        // beq taken
        add(0, T_BEQ, 0, 0, 1, fetch_exp(2'b10));
        add(0, T_BEQ, 0, 0, 1, decode_exp(2'b10));
        add(0, T_BEQ, 0, 0, 1, E(S_BEQ, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0));
        // beq not taken
        add(0, T_BEQ, 0, 0, 0, fetch_exp(2'b10));
        add(0, T_BEQ, 0, 0, 0, decode_exp(2'b10));
        add(0, T_BEQ, 0, 0, 0, E(S_BEQ, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0));
        // jal
        add(0, T_JAL, 0, 0, 0, fetch_exp(2'b11));
        add(0, T_JAL, 0, 0, 0, decode_exp(2'b11));
        add(0, T_JAL, 0, 0, 0, E(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0));
        add(0, T_JAL, 0, 0, 0, aluwb_exp(2'b11));
        // illegal opcode
        add(0, T_BAD, 0, 0, 0, fetch_exp(2'b00));
        add(0, T_BAD, 0, 0, 0, decode_exp(2'b00));
        add(0, T_BAD, 0, 0, 0, E(S_TRAP, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7 = vecs[i].f7; zero = vecs[i].z;
            #2;
            check($sformatf("vec%0d", i), vecs[i].ex);
        end

        // Trap is sticky for 20 more cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            check($sformatf("trap_hold%0d", i),
                  E(S_TRAP, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1));
        end
        @(negedge clk); reset = 1'b1; #2;
        check("trap_reset", reset_exp(2'b00));
        @(negedge clk); reset = 1'b0; op = T_SW; #2;
        check("trap_restart", fetch_exp(2'b01));

        // Reset mid-MEMWRITE cancels the write in the same cycle
        @(negedge clk); #2; check("rst_sw_decode", decode_exp(2'b01));
        @(negedge clk); #2;
        check("rst_sw_memadr", E(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0));
        @(negedge clk); #2;
        check("rst_sw_memwrite", E(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0));
        #1 reset = 1'b1; #1;
        check("rst_mid_memwrite", reset_exp(2'b01));
        @(negedge clk); reset = 1'b0; op = T_LW; #2;
        check("rst_release_fetch", fetch_exp(2'b00));

`ifdef MEM_WAIT_EN
        // FETCH waiting on memory: no IR or PC update
        mem_ready = 1'b0;
        #1;
        check("wait_fetch0", E(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0));
        @(negedge clk); #2;
        check("wait_fetch1", E(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0));
        mem_ready = 1'b1; #1;
        check("wait_fetch_go", fetch_exp(2'b00));
        @(negedge clk); #2; check("wait_decode", decode_exp(2'b00));
        @(negedge clk); #2;
        check("wait_memadr", E(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i == 3); #2;
            check($sformatf("wait_memread%0d", i),
                  E(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
        end
        @(negedge clk); #2;
        check("wait_memwb", E(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
